// File: rtl/pcu_pkg.sv
// Shared definitions for the Otter fetch-stage program-counter unit.
// Holds the next-PC source encoding and the target alignment mask.
package pcu_pkg;

  typedef enum logic [2:0] {
    SEL_PLUS4  = 3'd0,
    SEL_JALR   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JAL    = 3'd3,
    SEL_MTVEC  = 3'd4,
    SEL_MEPC   = 3'd5
  } pcu_sel_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pcu_ras.sv
// Circular return-address stack for call/return prediction.
// Pushing onto a full stack overwrites the oldest entry.
module pcu_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_valid
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  r_entry [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_replace;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(RAS_DEPTH));
  // Push+pop on an empty stack degenerates to a plain push.
  assign w_do_push    = i_en && i_push && (!i_pop || w_empty);
  assign w_do_replace = i_en && i_push && i_pop && !w_empty;
  assign w_do_pop     = i_en && !i_push && i_pop && !w_empty;
  assign w_ptr_inc    = r_ptr + PTR_W'(1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_ptr <= w_ptr_inc;
      if (!w_full) r_count <= r_count + CNT_W'(1);
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: the entry array has no reset; stale contents are masked by r_count, so it maps to plain RAM/flops without a reset tree.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_do_push)         r_entry[w_ptr_inc] <= i_data;
      else if (w_do_replace) r_entry[r_ptr]     <= i_data;
    end
  end

  assign o_valid = !w_empty;
  assign o_top   = w_empty ? '0 : r_entry[r_ptr];

endmodule

// File: rtl/pc_unit.sv
// Program counter for the Otter fetch stage: next-PC mux, misaligned-target
// trap to mtvec, and a return-address stack for call/return prediction.
module pc_unit
  import pcu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            PCU_clk,
  input  logic            PCU_rst,
  input  logic            PCU_write,
  input  logic [2:0]      PCU_sel,
  input  logic [XLEN-1:0] PCU_jalr,
  input  logic [XLEN-1:0] PCU_branch,
  input  logic [XLEN-1:0] PCU_jal,
  input  logic [XLEN-1:0] PCU_mtvec,
  input  logic [XLEN-1:0] PCU_mepc,
  input  logic            PCU_push,
  input  logic            PCU_pop,
  output logic [XLEN-1:0] PCU_count,
  output logic [XLEN-1:0] PCU_plus4,
  output logic [XLEN-1:0] PCU_ras_top,
  output logic            PCU_ras_valid,
  output logic            PCU_misalign,
  output logic [XLEN-1:0] PCU_bad_addr
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_bad_addr;
  logic            r_misalign;

  logic [XLEN-1:0] w_plus4;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_checked;
  logic            w_misaligned;

  assign w_plus4 = r_pc + XLEN'(4);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_target  = w_plus4;
    w_checked = 1'b0;
    case (PCU_sel)
      SEL_JALR:   begin w_target = PCU_jalr & ~XLEN'(1); w_checked = 1'b1; end
      SEL_BRANCH: begin w_target = PCU_branch;           w_checked = 1'b1; end
      SEL_JAL:    begin w_target = PCU_jal;              w_checked = 1'b1; end
      SEL_MTVEC:  w_target = PCU_mtvec;
      SEL_MEPC:   w_target = PCU_mepc;
      default:    w_target = w_plus4;
    endcase
  end

  assign w_misaligned = w_checked && ((w_target[1:0] & ALIGN_MASK) != 2'b00);
  assign w_next_pc    = w_misaligned ? PCU_mtvec : w_target;

  always_ff @(posedge PCU_clk) begin
    if (PCU_rst) begin
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
    end else if (PCU_write) begin
      r_pc       <= w_next_pc;
      r_misalign <= w_misaligned;
      if (w_misaligned) r_bad_addr <= w_target;
    end
  end

  // Calls push the return address of the current instruction.
  pcu_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (PCU_clk),
    .i_rst   (PCU_rst),
    .i_en    (PCU_write),
    .i_push  (PCU_push),
    .i_pop   (PCU_pop),
    .i_data  (w_plus4),
    .o_top   (PCU_ras_top),
    .o_valid (PCU_ras_valid)
  );

  assign PCU_count    = r_pc;
  assign PCU_plus4    = w_plus4;
  assign PCU_misalign = r_misalign;
  assign PCU_bad_addr = r_bad_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_pc_unit;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam int          RAS_DEPTH = 4;

  logic        PCU_clk = 1'b0;
  logic        PCU_rst = 1'b0;
  logic        PCU_write = 1'b0;
  logic [2:0]  PCU_sel = 3'd0;
  logic [31:0] PCU_jalr = '0, PCU_branch = '0, PCU_jal = '0, PCU_mtvec = '0, PCU_mepc = '0;
  logic        PCU_push = 1'b0, PCU_pop = 1'b0;
  logic [31:0] PCU_count, PCU_plus4, PCU_ras_top, PCU_bad_addr;
  logic        PCU_ras_valid, PCU_misalign;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc = RESET_VEC;
  logic [31:0] m_bad = '0;
  bit          m_mis = 1'b0;
  logic [31:0] m_ras[$];

  pc_unit #(.XLEN(XLEN), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .PCU_clk(PCU_clk), .PCU_rst(PCU_rst), .PCU_write(PCU_write), .PCU_sel(PCU_sel),
    .PCU_jalr(PCU_jalr), .PCU_branch(PCU_branch), .PCU_jal(PCU_jal),
    .PCU_mtvec(PCU_mtvec), .PCU_mepc(PCU_mepc), .PCU_push(PCU_push), .PCU_pop(PCU_pop),
    .PCU_count(PCU_count), .PCU_plus4(PCU_plus4), .PCU_ras_top(PCU_ras_top),
    .PCU_ras_valid(PCU_ras_valid), .PCU_misalign(PCU_misalign), .PCU_bad_addr(PCU_bad_addr)
  );

  always #5 PCU_clk = ~PCU_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a software stack kept newest-last, oldest dropped when full.
  task automatic model_step(input bit rst, input bit wr, input logic [2:0] sel,
                            input bit push, input bit pop);
    logic [31:0] p4, t;
    bit chk, mis;
    if (rst) begin
      m_pc = RESET_VEC; m_ras.delete(); m_mis = 1'b0; m_bad = '0;
    end else if (wr) begin
      p4 = m_pc + 32'd4;
      chk = 1'b1;
      case (sel)
        3'd1: t = PCU_jalr - (PCU_jalr % 2);
        3'd2: t = PCU_branch;
        3'd3: t = PCU_jal;
        3'd4: begin t = PCU_mtvec; chk = 1'b0; end
        3'd5: begin t = PCU_mepc;  chk = 1'b0; end
        default: begin t = p4; chk = 1'b0; end
      endcase
      mis = chk && (t % 4 != 0);
      if (push && pop && m_ras.size() > 0) m_ras[m_ras.size()-1] = p4;
      else if (push) begin
        if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(p4);
      end else if (pop && m_ras.size() > 0) void'(m_ras.pop_back());
      m_pc  = mis ? PCU_mtvec : t;
      m_mis = mis;
      if (mis) m_bad = t;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] top;
    top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    check({tag, ".pc"},       PCU_count,            m_pc);
    check({tag, ".plus4"},    PCU_plus4,            m_pc + 32'd4);
    check({tag, ".ras_top"},  PCU_ras_top,          top);
    check({tag, ".ras_vld"},  32'(PCU_ras_valid),   32'(m_ras.size() > 0));
    check({tag, ".misalign"}, 32'(PCU_misalign),    32'(m_mis));
    check({tag, ".bad_addr"}, PCU_bad_addr,         m_bad);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle(input string tag, input bit rst, input bit wr, input logic [2:0] sel,
                       input bit push, input bit pop);
    @(negedge PCU_clk);
    PCU_rst = rst; PCU_write = wr; PCU_sel = sel; PCU_push = push; PCU_pop = pop;
    @(posedge PCU_clk);
    model_step(rst, wr, sel, push, pop);
    #1;
    compare_all(tag);
  endtask

  function automatic logic [31:0] rnd_target();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 9) < 7) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    // 1: reset then sequential fetch
    cycle("rst", 1, 1, 3'd0, 0, 0);
    check("rst.pc_const", PCU_count, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle("seq", 0, 1, 3'd0, 0, 0);
      check("seq.pc_const", PCU_count, 32'(4 * i));
    end

    // 2: stall holds PC and ignores push
    cycle("to10", 0, 1, 3'd0, 0, 0);
    PCU_jal = 32'h200;
    for (int i = 0; i < 5; i++) cycle("stall", 0, 0, 3'd3, 1, 0);
    check("stall.pc_const", PCU_count, 32'h10);
    check("stall.ras_empty", 32'(PCU_ras_valid), 32'h0);

    // 3: JALR masking and misaligned branch trap
    PCU_jalr = 32'h101;
    cycle("jalr", 0, 1, 3'd1, 0, 0);
    check("jalr.pc_const", PCU_count, 32'h100);
    PCU_branch = 32'h102; PCU_mtvec = 32'h80;
    cycle("trap", 0, 1, 3'd2, 0, 0);
    check("trap.pc_const", PCU_count, 32'h80);
    check("trap.bad_const", PCU_bad_addr, 32'h102);
    check("trap.mis_const", 32'(PCU_misalign), 32'h1);
    cycle("trap_stall", 0, 0, 3'd0, 0, 0);
    cycle("trap_clear", 0, 1, 3'd0, 0, 0);
    check("trap_clear.mis_const", 32'(PCU_misalign), 32'h0);

    // 4: five calls overflow a 4-deep stack, then drain it
    cycle("rst4", 1, 1, 3'd0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      PCU_jal = 32'(16 * i);
      cycle("call", 0, 1, 3'd3, 1, 0);
    end
    check("call.top_const", PCU_ras_top, 32'h44);
    for (int i = 0; i < 5; i++) cycle("ret", 0, 1, 3'd0, 0, 1);
    check("ret.empty_const", 32'(PCU_ras_valid), 32'h0);

    // 5: push+pop replaces the top; on empty it acts as a push
    cycle("rst5", 1, 1, 3'd0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      PCU_jal = (i == 3) ? 32'h50 : 32'(16 * i);
      cycle("call5", 0, 1, 3'd3, 1, 0);
    end
    check("pp.pre_top_const", PCU_ras_top, 32'h24);
    cycle("pp", 0, 1, 3'd0, 1, 1);
    check("pp.top_const", PCU_ras_top, 32'h54);
    cycle("pp_pop", 0, 1, 3'd0, 0, 1);
    check("pp_pop.top_const", PCU_ras_top, 32'h14);
    cycle("rst5b", 1, 1, 3'd0, 0, 0);
    PCU_jal = 32'h50;
    cycle("to50", 0, 1, 3'd3, 0, 0);
    cycle("pp_empty", 0, 1, 3'd0, 1, 1);
    check("pp_empty.top_const", PCU_ras_top, 32'h54);
    cycle("pp_empty_pop", 0, 1, 3'd0, 0, 1);
    check("pp_empty_pop.vld_const", 32'(PCU_ras_valid), 32'h0);

    // 6: wrap-around, then reset during a push with a trap pending
    PCU_jal = 32'hFFFF_FFFC;
    cycle("tomax", 0, 1, 3'd3, 0, 0);
    cycle("wrap", 0, 1, 3'd0, 0, 0);
    check("wrap.pc_const", PCU_count, 32'h0);
    PCU_branch = 32'h6; PCU_mtvec = 32'h40;
    cycle("trap6", 0, 1, 3'd2, 1, 0);
    cycle("rst_push", 1, 1, 3'd0, 1, 0);
    check("rst_push.pc_const", PCU_count, RESET_VEC);
    check("rst_push.vld_const", 32'(PCU_ras_valid), 32'h0);
    check("rst_push.mis_const", 32'(PCU_misalign), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      PCU_jalr = rnd_target() | 32'($urandom_range(0, 1));
      PCU_branch = rnd_target(); PCU_jal = rnd_target();
      PCU_mtvec = {$urandom, 2'b00} >> 2 << 2; PCU_mepc = rnd_target();
      cycle("rnd", ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 8),
            3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
